fade_multi: RTL and testbench

Multi-channel, parametrised successor to the single-light fader. It drives CHANNELS independent fade envelopes: ramp up, hold high, ramp down, hold low. Channel start times are staggered by a fixed phase offset. The block also generates glitch-free PWM outputs from a shared period counter. Everything runs in one clock domain: step timing is a clock-enable pulse, never a derived clock. It sits between the top-level LED pins and the system clock.

---
 rtl/fade_if.sv | 28 ++
 rtl/fade_multi.sv | 164 ++++++++++++++++
 tb/tb_fade_multi.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fade_if.sv
// Control inputs and observed outputs of the multi-channel fader, grouped as one bundle.
// The master side drives the controls; the slave side is the fader itself.
interface fade_if #(
   parameter int CHANNELS = 3,
   parameter int DW       = 11
) ();
   logic                   enable;
   logic                   restart;
   logic                   hold_bypass;
   logic [CHANNELS*DW-1:0] duty_cycle;
   logic [CHANNELS-1:0]    pwm_out;

   modport master (
      output enable,
      output restart,
      output hold_bypass,
      input  duty_cycle,
      input  pwm_out
   );

   modport slave (
      input  enable,
      input  restart,
      input  hold_bypass,
      output duty_cycle,
      output pwm_out
   );
endinterface

// File: rtl/fade_multi.sv
// Multi-channel fade envelope generator with phase-staggered channels and glitch-free PWM.
// Step timing is a clock-enable tick; PWM duty updates only at period boundaries.
module fade_multi #(
   parameter int CHANNELS      = 3,
   parameter int STEP_INTERVAL = 12000,
   parameter int STEP_MAX      = 166,
   parameter int HOLD_STEPS    = 332,
   parameter int PWM_INTERVAL  = 1200,
   parameter int PHASE_STEPS   = 111,
   parameter int STEP_SIZE     = PWM_INTERVAL / STEP_MAX,
   parameter int DW            = $clog2(PWM_INTERVAL + 1)
) (
   input logic   clk,
   input logic   rst_n,
   fade_if.slave bus
);
   localparam int DUTY_MAX  = STEP_MAX * STEP_SIZE;
   localparam int TW        = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
   localparam int PW        = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
   localparam int PHASE_MAX = (CHANNELS - 1) * PHASE_STEPS;
   localparam int SEG_A     = (STEP_MAX > HOLD_STEPS) ? STEP_MAX : HOLD_STEPS;
   localparam int SEG_MAX   = (SEG_A > PHASE_MAX) ? SEG_A : PHASE_MAX;
   localparam int SEG_W     = $clog2(SEG_MAX + 1);

   localparam logic [TW-1:0]        TICK_LAST = TW'(STEP_INTERVAL - 1);
   localparam logic [PW-1:0]        PWM_LAST  = PW'(PWM_INTERVAL - 1);
   localparam logic [SEG_W-1:0]     RAMP_LAST = SEG_W'(STEP_MAX - 1);
   localparam logic [SEG_W-1:0]     HOLD_LAST = SEG_W'(HOLD_STEPS - 1);
   localparam logic signed [DW+1:0] STEP_S    = (DW+2)'(STEP_SIZE);
   localparam logic signed [DW+1:0] TOP_S     = (DW+2)'(DUTY_MAX);
   localparam logic [DW-1:0]        DUTY_TOP  = DW'(DUTY_MAX);

   typedef enum logic [2:0] {
      S_WAIT    = 3'd0,
      S_INC     = 3'd1,
      S_HOLD_HI = 3'd2,
      S_DEC     = 3'd3,
      S_HOLD_LO = 3'd4
   } state_t;

   // One ramp step, clamped to [0, DUTY_MAX] as a guard against bad parameter sets.
   function automatic logic [DW-1:0] step_duty(input logic [DW-1:0] duty, input logic up);
      logic signed [DW+1:0] nxt;
      nxt = up ? ($signed({2'b00, duty}) + STEP_S) : ($signed({2'b00, duty}) - STEP_S);
      if (nxt[DW+1])   return '0;
      if (nxt > TOP_S) return DUTY_TOP;
      return nxt[DW-1:0];
   endfunction

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [PW-1:0] pwm_cnt;
   logic          period_end;
   logic [DW-1:0] duty_w [CHANNELS];
   logic          pwm_w  [CHANNELS];

   assign tick       = bus.enable && (tick_cnt == TICK_LAST);
   assign period_end = (pwm_cnt == PWM_LAST);

   // Step timer: frozen (not cleared) while enable is low, so no tick is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            tick_cnt <= '0;
      else if (bus.restart)  tick_cnt <= '0;
      else if (tick)         tick_cnt <= '0;
      else if (bus.enable)   tick_cnt <= tick_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            pwm_cnt <= '0;
      else if (bus.restart)  pwm_cnt <= '0;
      else if (period_end)   pwm_cnt <= '0;
      else                   pwm_cnt <= pwm_cnt + 1'b1;
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam int               WAIT_STEPS = k * PHASE_STEPS;
      localparam state_t           START_ST   = (WAIT_STEPS == 0) ? S_INC : S_WAIT;
      localparam logic [SEG_W-1:0] WAIT_LAST  = SEG_W'((WAIT_STEPS > 0) ? WAIT_STEPS - 1 : 0);

      state_t           state_q, state_d;
      logic [SEG_W-1:0] seg_q, seg_d;
      logic [DW-1:0]    duty_q, duty_d;
      logic             seg_done;
      logic [DW-1:0]    shadow_q;
      logic             pwm_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= START_ST;
            seg_q   <= '0;
            duty_q  <= '0;
         end else if (bus.restart) begin
            state_q <= START_ST;
            seg_q   <= '0;
            duty_q  <= '0;
         end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            duty_q  <= duty_d;
         end
      end

      // Hold segments end early whenever bypass is seen on a tick.
      always_comb begin
         state_d  = state_q;
         seg_d    = seg_q;
         seg_done = 1'b0;
         case (state_q)
            S_WAIT:               seg_done = (seg_q == WAIT_LAST);
            S_INC, S_DEC:         seg_done = (seg_q == RAMP_LAST);
            S_HOLD_HI, S_HOLD_LO: seg_done = bus.hold_bypass || (seg_q == HOLD_LAST);
            default:              seg_done = 1'b1;
         endcase
         if (tick && seg_done) begin
            case (state_q)
               S_WAIT:    state_d = S_INC;
               S_INC:     state_d = bus.hold_bypass ? S_DEC : S_HOLD_HI;
               S_HOLD_HI: state_d = S_DEC;
               S_DEC:     state_d = bus.hold_bypass ? S_INC : S_HOLD_LO;
               S_HOLD_LO: state_d = S_INC;
               default:   state_d = START_ST;
            endcase
         end
         if (tick) seg_d = (state_d != state_q) ? '0 : seg_q + 1'b1;
      end

      always_comb begin
         duty_d = duty_q;
         if (tick && (state_q == S_INC))      duty_d = step_duty(duty_q, 1'b1);
         else if (tick && (state_q == S_DEC)) duty_d = step_duty(duty_q, 1'b0);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
         end else if (bus.restart) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
         end else begin
            if (period_end) shadow_q <= duty_q;
            pwm_q <= (DW'(pwm_cnt) < shadow_q);
         end
      end

      assign duty_w[k] = duty_q;
      assign pwm_w[k]  = pwm_q;
   end

   logic [CHANNELS*DW-1:0] duty_pack;
   logic [CHANNELS-1:0]    pwm_pack;

   always_comb begin
      duty_pack = '0;
      pwm_pack  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         duty_pack[k*DW +: DW] = duty_w[k];
         pwm_pack[k]           = pwm_w[k];
      end
   end

   assign bus.duty_cycle = duty_pack;
   assign bus.pwm_out    = pwm_pack;
endmodule

// File: tb/tb_fade_multi.sv
// Scoreboard bench for fade_multi: a level/direction envelope model predicts every cycle,
// a monitor compares outputs, and a few fixed-edge checks anchor the absolute timing.
module tb_fade_multi;
   localparam int CH   = 3;
   localparam int SI   = 4;
   localparam int SM   = 5;
   localparam int HS   = 3;
   localparam int PI   = 20;
   localparam int PS   = 2;
   localparam int SS   = PI / SM;
   localparam int DMAX = SM * SS;
   localparam int DW   = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fade_if #(.CHANNELS(CH), .DW(DW)) bus ();

   fade_multi #(
      .CHANNELS(CH), .STEP_INTERVAL(SI), .STEP_MAX(SM), .HOLD_STEPS(HS),
      .PWM_INTERVAL(PI), .PHASE_STEPS(PS), .STEP_SIZE(SS), .DW(DW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      int          duty [CH];
      bit [CH-1:0] pwm;
   } exp_t;

   typedef struct {
      int mode;
      int edg;
      int ch;
      int val;
   } dir_t;

   exp_t sb_q [$];

   // Fixed expectations counted in rising edges since reset release / restart.
   dir_t dir_tab [21] = '{
      '{1, 4, 0, 4},  '{1, 20, 0, 20}, '{1, 32, 0, 20}, '{1, 36, 0, 16}, '{1, 52, 0, 0},
      '{1, 68, 0, 4}, '{1, 11, 1, 0},  '{1, 12, 1, 4},  '{1, 19, 2, 0},  '{1, 20, 2, 4},
      '{1, 76, 1, 4}, '{1, 84, 2, 4},
      '{2, 20, 0, 20}, '{2, 24, 0, 16}, '{2, 40, 0, 0}, '{2, 44, 0, 4}, '{2, 84, 0, 4},
      '{3, 9, 0, 8},  '{3, 19, 0, 8},  '{3, 21, 0, 8},  '{3, 22, 0, 12}
   };

   // Reference model: envelope as level in STEP_SIZE units plus a direction.
   int          m_en_cnt;
   int          m_pcyc;
   int          m_lvl    [CH];
   int          m_dir    [CH];
   int          m_wait   [CH];
   int          m_hold   [CH];
   bit          m_inhold [CH];
   int          m_shadow [CH];
   bit [CH-1:0] m_pwm;

   function automatic void model_reset();
      m_en_cnt = 0;
      m_pcyc   = 0;
      m_pwm    = '0;
      for (int k = 0; k < CH; k++) begin
         m_lvl[k]    = 0;
         m_dir[k]    = 1;
         m_wait[k]   = k * PS;
         m_hold[k]   = 0;
         m_inhold[k] = 1'b0;
         m_shadow[k] = 0;
      end
   endfunction

   function automatic void model_step(input bit en, input bit byp);
      bit tk;
      tk = en && (m_en_cnt == SI - 1);
      for (int k = 0; k < CH; k++) m_pwm[k] = (m_pcyc < m_shadow[k]);
      if (m_pcyc == PI - 1)
         for (int k = 0; k < CH; k++) m_shadow[k] = m_lvl[k] * SS;
      m_pcyc = (m_pcyc + 1) % PI;
      if (en) m_en_cnt = (m_en_cnt + 1) % SI;
      if (tk) begin
         for (int k = 0; k < CH; k++) begin
            if (m_wait[k] > 0) begin
               m_wait[k]--;
            end else if (m_inhold[k]) begin
               m_hold[k]++;
               if (byp || m_hold[k] == HS) begin
                  m_inhold[k] = 1'b0;
                  m_hold[k]   = 0;
                  m_dir[k]    = -m_dir[k];
               end
            end else begin
               m_lvl[k] += m_dir[k];
               if ((m_dir[k] > 0 && m_lvl[k] == SM) || (m_dir[k] < 0 && m_lvl[k] == 0)) begin
                  if (byp) m_dir[k] = -m_dir[k];
                  else     m_inhold[k] = 1'b1;
               end
            end
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      if (!rst_n || bus.restart) model_reset();
      else                       model_step(bus.enable, bus.hold_bypass);
      for (int k = 0; k < CH; k++) e.duty[k] = m_lvl[k] * SS;
      e.pwm = m_pwm;
      sb_q.push_back(e);
   end

   int n_cmp    = 0;
   int n_bad    = 0;
   int edge_n   = 0;
   int dir_mode = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
      end
   endtask

   // Monitor: one expectation per clock edge or asynchronous reset assertion.
   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      int   d;
      #1;
      if (clk) begin
         if (!rst_n || bus.restart) edge_n = 0;
         else                       edge_n++;
      end else begin
         edge_n = 0;
      end
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 0, 1);
      end else begin
         e = sb_q.pop_front();
         for (int k = 0; k < CH; k++) begin
            d = int'(bus.duty_cycle[k*DW +: DW]);
            chk($sformatf("duty_ch%0d", k), d, e.duty[k]);
            chk($sformatf("duty_range_ch%0d", k), int'(d >= 0 && d <= DMAX), 1);
         end
         chk("pwm_out", int'(bus.pwm_out), int'(e.pwm));
      end
      if (clk) begin
         foreach (dir_tab[i]) begin
            if (dir_tab[i].mode == dir_mode && dir_tab[i].edg == edge_n) begin
               d = int'(bus.duty_cycle[dir_tab[i].ch*DW +: DW]);
               chk($sformatf("fixed_m%0d_e%0d_ch%0d", dir_tab[i].mode, edge_n, dir_tab[i].ch),
                   d, dir_tab[i].val);
            end
         end
      end
   end

   initial begin
      bus.enable      = 1'b1;
      bus.restart     = 1'b0;
      bus.hold_bypass = 1'b0;
      dir_mode        = 1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (140) @(negedge clk);

      // Restart with hold bypass from the start.
      dir_mode        = 2;
      bus.hold_bypass = 1'b1;
      bus.restart     = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      repeat (100) @(negedge clk);

      // Restart, then freeze for 10 cycles mid-ramp.
      dir_mode        = 3;
      bus.hold_bypass = 1'b0;
      bus.restart     = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      repeat (9) @(negedge clk);
      bus.enable = 1'b0;
      repeat (10) @(negedge clk);
      bus.enable = 1'b1;
      repeat (40) @(negedge clk);
      dir_mode = 0;

      for (int i = 0; i < 4000; i++) begin
         bus.restart = ($urandom_range(0, 299) == 0);
         if (bus.enable) begin
            if ($urandom_range(0, 11) == 0) bus.enable = 1'b0;
         end else begin
            if ($urandom_range(0, 3) == 0) bus.enable = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) bus.hold_bypass = ~bus.hold_bypass;
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end

      bus.restart = 1'b0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
